neighbor_table_ctrl: RTL and testbench

Controller that sequences the 32-entry neighbor table. It accepts neighbor-update requests from QTableUpdate and scans its own shadow of valid bits and node IDs. A request either overwrites the slot that already holds that node ID or allocates the first free slot. The controller then drives the table's write enable and slot index, arbitrates slot reads from the CH-timeslot logic, and sequences heartbeat (HB) clears.

---
 rtl/nt_pkg.sv | 18 +
 rtl/neighbor_table_ctrl_if.sv | 32 +++
 rtl/nt_slot_scanner.sv | 60 ++++++
 rtl/neighbor_table_ctrl.sv | 140 ++++++++++++++
 tb/tb_neighbor_table_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/nt_pkg.sv
// rtl/nt_pkg.sv - shared types and sizing for the neighbor table controller
package nt_pkg;

    localparam int WORD_WIDTH  = 16;
    localparam int TABLE_DEPTH = 32;
    localparam int IDX_W       = $clog2(TABLE_DEPTH);

    localparam logic [WORD_WIDTH-1:0] MY_NODE_ID_CONST = 16'h000C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_CLEAR,
        S_READ
    } nt_state_e;

endpackage

// File: rtl/neighbor_table_ctrl_if.sv
// rtl/neighbor_table_ctrl_if.sv - update, heartbeat, read and table-strobe signals
interface neighbor_table_ctrl_if;
    import nt_pkg::*;

    logic                  upd_valid;
    logic [WORD_WIDTH-1:0] upd_node_id;
    logic                  upd_ready;
    logic                  hb_reset;
    logic                  rd_req;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_valid;
    logic                  rd_hit;
    logic                  tbl_wr_en;
    logic [IDX_W-1:0]      tbl_idx;
    logic                  tbl_hb_reset;
    logic [IDX_W:0]        nbr_count;
    logic                  tbl_full;
    logic                  drop;

    modport master (
        output upd_valid, upd_node_id, hb_reset, rd_req, rd_idx,
        input  upd_ready, rd_valid, rd_hit, tbl_wr_en, tbl_idx,
               tbl_hb_reset, nbr_count, tbl_full, drop
    );

    modport slave (
        input  upd_valid, upd_node_id, hb_reset, rd_req, rd_idx,
        output upd_ready, rd_valid, rd_hit, tbl_wr_en, tbl_idx,
               tbl_hb_reset, nbr_count, tbl_full, drop
    );

endinterface

// File: rtl/nt_slot_scanner.sv
// rtl/nt_slot_scanner.sv - walks the slots one per cycle looking for a matching or free entry
module nt_slot_scanner
    import nt_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  nrst,
    input  logic                                  start,
    input  logic                                  step,
    input  logic [WORD_WIDTH-1:0]                 key,
    input  logic [TABLE_DEPTH-1:0]                valid_vec,
    input  logic [TABLE_DEPTH-1:0][WORD_WIDTH-1:0] id_vec,
    output logic                                  done,
    output logic                                  hit,
    output logic [IDX_W-1:0]                      target
);

    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic             free_found_q, free_found_d;
    logic             cur_valid;
    logic             cur_match;
    logic             last;

    always_comb begin
        cur_valid = valid_vec[cnt_q];
        cur_match = cur_valid && (id_vec[cnt_q] == key);
        last      = (cnt_q == IDX_W'(TABLE_DEPTH - 1));
        done      = step && (cur_match || last);
        // On the last slot an invalid entry is itself the first free slot
        hit       = cur_match || free_found_q || !cur_valid;
        target    = cur_match ? cnt_q : (free_found_q ? free_idx_q : cnt_q);

        cnt_d        = cnt_q;
        free_found_d = free_found_q;
        free_idx_d   = free_idx_q;
        if (start) begin
            cnt_d        = '0;
            free_found_d = 1'b0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (!cur_valid && !free_found_q) begin
                free_found_d = 1'b1;
                free_idx_d   = cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            cnt_q        <= '0;
            free_idx_q   <= '0;
            free_found_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            free_idx_q   <= free_idx_d;
            free_found_q <= free_found_d;
        end
    end

endmodule

// File: rtl/neighbor_table_ctrl.sv
// rtl/neighbor_table_ctrl.sv - sequences updates, heartbeat clears and reads of the neighbor table
module neighbor_table_ctrl
    import nt_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] MY_NODE_ID = MY_NODE_ID_CONST
) (
    input logic                  clk,
    input logic                  nrst,
    neighbor_table_ctrl_if.slave bus
);

    nt_state_e                             state_q, state_d;
    logic [WORD_WIDTH-1:0]                 key_q, key_d;
    logic [IDX_W-1:0]                      tbl_idx_q, tbl_idx_d;
    logic [TABLE_DEPTH-1:0]                valid_q, valid_d;
    logic [TABLE_DEPTH-1:0][WORD_WIDTH-1:0] ids_q, ids_d;
    logic [IDX_W:0]                        count_q, count_d;
    logic                                  drop_q, drop_d;
    logic                                  rd_valid_q, rd_valid_d;
    logic                                  rd_hit_q, rd_hit_d;

    logic             scan_start;
    logic             scan_step;
    logic             scan_done;
    logic             scan_hit;
    logic [IDX_W-1:0] scan_target;

    nt_slot_scanner u_scanner (
        .clk       (clk),
        .nrst      (nrst),
        .start     (scan_start),
        .step      (scan_step),
        .key       (key_q),
        .valid_vec (valid_q),
        .id_vec    (ids_q),
        .done      (scan_done),
        .hit       (scan_hit),
        .target    (scan_target)
    );

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        tbl_idx_d  = tbl_idx_q;
        valid_d    = valid_q;
        ids_d      = ids_q;
        count_d    = count_q;
        drop_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_hit_d   = 1'b0;
        scan_start = 1'b0;
        scan_step  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.hb_reset) begin
                    state_d = S_CLEAR;
                end else if (bus.upd_valid) begin
                    key_d = bus.upd_node_id;
                    if (bus.upd_node_id == MY_NODE_ID) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d    = S_SCAN;
                        scan_start = 1'b1;
                    end
                end else if (bus.rd_req) begin
                    tbl_idx_d = bus.rd_idx;
                    state_d   = S_READ;
                end
            end
            S_SCAN: begin
                scan_step = 1'b1;
                if (scan_done) begin
                    if (scan_hit) begin
                        tbl_idx_d = scan_target;
                        state_d   = S_WRITE;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                valid_d[tbl_idx_q] = 1'b1;
                ids_d[tbl_idx_q]   = key_q;
                if (!valid_q[tbl_idx_q]) begin
                    count_d = count_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                valid_d = '0;
                count_d = '0;
                state_d = S_IDLE;
            end
            S_READ: begin
                // The table read is registered, so its data lands one cycle after tbl_idx
                rd_valid_d = 1'b1;
                rd_hit_d   = valid_q[tbl_idx_q];
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            tbl_idx_q  <= '0;
            valid_q    <= '0;
            ids_q      <= '0;
            count_q    <= '0;
            drop_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            tbl_idx_q  <= tbl_idx_d;
            valid_q    <= valid_d;
            ids_q      <= ids_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
        end
    end

    assign bus.upd_ready    = (state_q == S_IDLE) && !nrst;
    assign bus.tbl_wr_en    = (state_q == S_WRITE);
    assign bus.tbl_hb_reset = (state_q == S_CLEAR);
    assign bus.tbl_idx      = tbl_idx_q;
    assign bus.nbr_count    = count_q;
    assign bus.tbl_full     = (count_q == (IDX_W + 1)'(TABLE_DEPTH));
    assign bus.drop         = drop_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_hit       = rd_hit_q;

endmodule

// File: tb/tb_neighbor_table_ctrl.sv
// tb/tb_neighbor_table_ctrl.sv - directed self-checking bench for neighbor_table_ctrl
module tb_neighbor_table_ctrl;

    logic clk;
    logic nrst;
    int   n_cmp;
    int   n_err;
    int   wr_pulses;
    int   drop_pulses;
    int   hb_pulses;

    neighbor_table_ctrl_if bus ();

    neighbor_table_ctrl dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tbl_wr_en)    wr_pulses++;
        if (bus.drop)         drop_pulses++;
        if (bus.tbl_hb_reset) hb_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns cycles from the accepting edge to the first wr_en or drop, and which one fired
    task automatic send_upd(input logic [15:0] id, output int lat, output bit wr, output int idx);
        int t;
        bus.upd_valid   = 1'b1;
        bus.upd_node_id = id;
        t = 0;
        while (!bus.upd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("upd_accepted", 32'(bus.upd_ready), 32'd1);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        lat = 1;
        while (!(bus.tbl_wr_en || bus.drop) && lat <= 40) begin
            @(negedge clk);
            lat++;
        end
        wr  = bus.tbl_wr_en;
        idx = 32'(bus.tbl_idx);
        @(negedge clk);
    endtask

    task automatic do_read(input logic [4:0] idx, input logic exp_hit);
        bus.rd_req = 1'b1;
        bus.rd_idx = idx;
        @(negedge clk);
        bus.rd_req = 1'b0;
        check_eq("rd_valid_early", 32'(bus.rd_valid), 32'd0);
        @(negedge clk);
        check_eq("rd_valid", 32'(bus.rd_valid), 32'd1);
        check_eq("rd_hit", 32'(bus.rd_hit), 32'(exp_hit));
        check_eq("rd_tbl_idx", 32'(bus.tbl_idx), 32'(idx));
        @(negedge clk);
        check_eq("rd_valid_pulse", 32'(bus.rd_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  wr;
        int  idx;
        int  wr0;
        int  dr0;
        int  hb0;

        n_cmp = 0; n_err = 0;
        wr_pulses = 0; drop_pulses = 0; hb_pulses = 0;
        nrst            = 1'b1;
        bus.upd_valid   = 1'b0;
        bus.upd_node_id = '0;
        bus.hb_reset    = 1'b0;
        bus.rd_req      = 1'b0;
        bus.rd_idx      = '0;
        repeat (3) @(negedge clk);

        check_eq("rst_upd_ready", 32'(bus.upd_ready), 32'd0);
        check_eq("rst_nbr_count", 32'(bus.nbr_count), 32'd0);
        check_eq("rst_tbl_full", 32'(bus.tbl_full), 32'd0);
        check_eq("rst_drop", 32'(bus.drop), 32'd0);
        check_eq("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check_eq("rst_tbl_idx", 32'(bus.tbl_idx), 32'd0);
        check_eq("rst_wr_en", 32'(bus.tbl_wr_en), 32'd0);
        nrst = 1'b0;
        @(negedge clk);
        check_eq("idle_upd_ready", 32'(bus.upd_ready), 32'd1);

        // First allocation scans every slot before writing the first free one
        send_upd(16'h0021, lat, wr, idx);
        check_eq("alloc_lat", 32'(lat), 32'd33);
        check_eq("alloc_wr", 32'(wr), 32'd1);
        check_eq("alloc_idx", 32'(idx), 32'd0);
        check_eq("alloc_count", 32'(bus.nbr_count), 32'd1);

        send_upd(16'h0021, lat, wr, idx);
        check_eq("match_lat", 32'(lat), 32'd2);
        check_eq("match_wr", 32'(wr), 32'd1);
        check_eq("match_idx", 32'(idx), 32'd0);
        check_eq("match_count", 32'(bus.nbr_count), 32'd1);

        wr0 = wr_pulses;
        send_upd(16'h000C, lat, wr, idx);
        check_eq("own_lat", 32'(lat), 32'd1);
        check_eq("own_is_drop", 32'(wr), 32'd0);
        check_eq("own_drop_pulse", 32'(bus.drop), 32'd0);
        check_eq("own_no_wr", 32'(wr_pulses), 32'(wr0));
        check_eq("own_count", 32'(bus.nbr_count), 32'd1);

        // hb_reset outranks a simultaneous update
        bus.hb_reset    = 1'b1;
        bus.upd_valid   = 1'b1;
        bus.upd_node_id = 16'h0033;
        @(negedge clk);
        check_eq("hb_strobe", 32'(bus.tbl_hb_reset), 32'd1);
        check_eq("hb_no_wr", 32'(bus.tbl_wr_en), 32'd0);
        bus.hb_reset = 1'b0;
        @(negedge clk);
        check_eq("hb_count", 32'(bus.nbr_count), 32'd0);
        check_eq("hb_strobe_pulse", 32'(bus.tbl_hb_reset), 32'd0);
        send_upd(16'h0033, lat, wr, idx);
        check_eq("post_hb_wr", 32'(wr), 32'd1);
        check_eq("post_hb_idx", 32'(idx), 32'd0);
        check_eq("post_hb_count", 32'(bus.nbr_count), 32'd1);

        bus.hb_reset = 1'b1;
        @(negedge clk);
        bus.hb_reset = 1'b0;
        @(negedge clk);
        check_eq("clear2_count", 32'(bus.nbr_count), 32'd0);

        for (int i = 0; i < 32; i++) begin
            send_upd(16'h0100 + 16'(i), lat, wr, idx);
            check_eq("fill_lat", 32'(lat), 32'd33);
            check_eq("fill_idx", 32'(idx), 32'(i));
        end
        check_eq("full_count", 32'(bus.nbr_count), 32'd32);
        check_eq("full_flag", 32'(bus.tbl_full), 32'd1);

        send_upd(16'h0200, lat, wr, idx);
        check_eq("full_drop_lat", 32'(lat), 32'd33);
        check_eq("full_drop", 32'(wr), 32'd0);
        check_eq("full_drop_count", 32'(bus.nbr_count), 32'd32);

        send_upd(16'h0105, lat, wr, idx);
        check_eq("overwrite_lat", 32'(lat), 32'd7);
        check_eq("overwrite_idx", 32'(idx), 32'd5);
        check_eq("overwrite_count", 32'(bus.nbr_count), 32'd32);

        do_read(5'd3, 1'b1);

        // Reset in the middle of a scan must leave no strobe behind
        wr0 = wr_pulses; dr0 = drop_pulses; hb0 = hb_pulses;
        bus.upd_valid   = 1'b1;
        bus.upd_node_id = 16'h0400;
        @(negedge clk);
        bus.upd_valid = 1'b0;
        repeat (4) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_upd_ready", 32'(bus.upd_ready), 32'd0);
        check_eq("mid_rst_count", 32'(bus.nbr_count), 32'd0);
        check_eq("mid_rst_full", 32'(bus.tbl_full), 32'd0);
        check_eq("mid_rst_tbl_idx", 32'(bus.tbl_idx), 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("mid_rst_no_wr", 32'(wr_pulses), 32'(wr0));
        check_eq("mid_rst_no_drop", 32'(drop_pulses), 32'(dr0));
        check_eq("mid_rst_no_hb", 32'(hb_pulses), 32'(hb0));
        check_eq("mid_rst_ready", 32'(bus.upd_ready), 32'd1);

        do_read(5'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
